// File: rtl/mem_responder_if.sv
// mem_responder_if
// Request/response bundle between the MEM-stage load/store path (master)
// and the multi-cycle data memory (slave).
//   req_valid/req_write/req_addr/req_wdata : request from the core
//   stall                                  : freeze the pipeline
//   rd_data/rd_valid                       : registered load result + pulse
interface mem_responder_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic [31:0] rd_data;
  logic        rd_valid;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  stall, rd_data, rd_valid
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output stall, rd_data, rd_valid
  );
endinterface

// File: rtl/mem_responder.sv
// mem_responder
// Multi-cycle word data memory for the MEM stage. Accepts one load or store
// at a time, holds stall for LATENCY+1 cycles, then commits the store or
// presents the load result for one cycle in DONE.
// Ports:
//   clk   : clock, rising edge
//   reset : asynchronous, active-low
//   bus   : mem_responder_if.slave (request in, stall/rd_data/rd_valid out)
//
// state | meaning
// IDLE  | waiting for req_valid; latches the request
// BUSY  | counting down the access latency; access happens when count is 0
// DONE  | result presented, pipeline advances; req_valid ignored
module mem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3
) (
  input logic             clk,
  input logic             reset,
  mem_responder_if.slave  bus
);

  localparam int         IDX_W    = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic [3:0]         count;
  logic               lat_write;
  logic [IDX_W-1:0]   lat_idx;
  logic [31:0]        lat_wdata;
  logic [31:0]        rd_data_q;
  logic               rd_valid_q;
  logic               access_now;
  logic               unused_addr_bits;

  // Storage is deliberately outside the reset domain: contents survive reset.
  logic [31:0]        mem [DEPTH];

  assign access_now = (state == BUSY) && (count == 4'd0);

  // Only byte-offset and above-index bits are dropped: misaligned addresses
  // truncate and high addresses wrap modulo DEPTH.
  assign unused_addr_bits = ^{bus.req_addr[31:IDX_W+2], bus.req_addr[1:0]};

  // A store commits only on the BUSY->DONE edge; reset forces IDLE so an
  // interrupted store never reaches this write.
  always_ff @(posedge clk) begin
    if (access_now && lat_write) begin
      mem[lat_idx] <= lat_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= 4'd0;
      lat_write  <= 1'b0;
      lat_idx    <= '0;
      lat_wdata  <= 32'd0;
      rd_data_q  <= 32'd0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            lat_write <= bus.req_write;
            lat_idx   <= bus.req_addr[IDX_W+1:2];
            lat_wdata <= bus.req_wdata;
            count     <= CNT_INIT;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (count != 4'd0) begin
            count <= count - 4'd1;
          end else begin
            if (!lat_write) begin
              rd_data_q  <= mem[lat_idx];
              rd_valid_q <= 1'b1;
            end
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Combinational so the pipeline freezes in the same cycle the request
  // appears; gated by reset so it drops the instant reset asserts.
  assign bus.stall    = reset && (((state == IDLE) && bus.req_valid) || (state == BUSY));
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  int          sel;

  logic        obs_stall;
  logic        obs_rd_valid;
  logic [31:0] obs_rd_data;

  int n_vec;
  int n_err;

  mem_responder_if if0 ();
  mem_responder_if if1 ();
  mem_responder_if if2 ();

  assign if0.req_valid = req_valid && (sel == 0);
  assign if1.req_valid = req_valid && (sel == 1);
  assign if2.req_valid = req_valid && (sel == 2);
  assign if0.req_write = req_write;
  assign if1.req_write = req_write;
  assign if2.req_write = req_write;
  assign if0.req_addr  = req_addr;
  assign if1.req_addr  = req_addr;
  assign if2.req_addr  = req_addr;
  assign if0.req_wdata = req_wdata;
  assign if1.req_wdata = req_wdata;
  assign if2.req_wdata = req_wdata;

  mem_responder #(.DEPTH(256), .LATENCY(3))  u0 (.clk(clk), .reset(reset), .bus(if0));
  mem_responder #(.DEPTH(256), .LATENCY(1))  u1 (.clk(clk), .reset(reset), .bus(if1));
  mem_responder #(.DEPTH(256), .LATENCY(15)) u2 (.clk(clk), .reset(reset), .bus(if2));

  always_comb begin
    obs_stall    = if0.stall;
    obs_rd_valid = if0.rd_valid;
    obs_rd_data  = if0.rd_data;
    case (sel)
      1: begin
        obs_stall    = if1.stall;
        obs_rd_valid = if1.rd_valid;
        obs_rd_data  = if1.rd_data;
      end
      2: begin
        obs_stall    = if2.stall;
        obs_rd_valid = if2.rd_valid;
        obs_rd_data  = if2.rd_data;
      end
      default: ;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Presents a request at a negedge and holds it (including through DONE).
  // Returns in the DONE cycle, or after a bounded number of stalled cycles.
  task automatic access(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        output int stall_n, output int rdv_busy,
                        output logic done_rdv, output logic [31:0] done_data);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    stall_n   = 0;
    rdv_busy  = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!obs_stall) break;
      stall_n++;
      if (obs_rd_valid) rdv_busy++;
      @(negedge clk);
    end
    done_rdv  = obs_rd_valid;
    done_data = obs_rd_data;
  endtask

  task automatic idle(output logic s, output logic v);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    s = obs_stall;
    v = obs_rd_valid;
  endtask

  task automatic test_reset;
    reset     = 1'b0;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      sel = k;
      #1;
      n_vec++;
      if (obs_stall !== 1'b0) begin
        n_err++; $display("FAIL rst_stall[%0d]: got %b expected 0", k, obs_stall);
      end
      n_vec++;
      if (obs_rd_valid !== 1'b0) begin
        n_err++; $display("FAIL rst_rd_valid[%0d]: got %b expected 0", k, obs_rd_valid);
      end
      n_vec++;
      if (obs_rd_data !== 32'h0) begin
        n_err++; $display("FAIL rst_rd_data[%0d]: got %h expected 00000000", k, obs_rd_data);
      end
    end
    sel       = 0;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_store_load;
    int s_n, r_b; logic d_v, s, v; logic [31:0] d;
    access(1'b1, 32'h10, 32'hDEADBEEF, s_n, r_b, d_v, d);
    n_vec++;
    if (s_n !== 4) begin n_err++; $display("FAIL sl_store_stall: got %0d expected 4", s_n); end
    n_vec++;
    if (r_b !== 0 || d_v !== 1'b0) begin
      n_err++; $display("FAIL sl_store_rdv: got busy=%0d done=%b expected 0/0", r_b, d_v);
    end
    n_vec++;
    if (d !== 32'h0) begin n_err++; $display("FAIL sl_store_rd_data: got %h expected 00000000", d); end
    idle(s, v);
    access(1'b0, 32'h10, 32'h0, s_n, r_b, d_v, d);
    n_vec++;
    if (s_n !== 4) begin n_err++; $display("FAIL sl_load_stall: got %0d expected 4", s_n); end
    n_vec++;
    if (d_v !== 1'b1 || r_b !== 0) begin
      n_err++; $display("FAIL sl_load_rdv: got busy=%0d done=%b expected 0/1", r_b, d_v);
    end
    n_vec++;
    if (d !== 32'hDEADBEEF) begin n_err++; $display("FAIL sl_load_data: got %h expected deadbeef", d); end
    idle(s, v);
    n_vec++;
    if (v !== 1'b0 || s !== 1'b0) begin
      n_err++; $display("FAIL sl_after_done: got stall=%b rdv=%b expected 0/0", s, v);
    end
    n_vec++;
    if (obs_rd_data !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL sl_rd_data_hold: got %h expected deadbeef", obs_rd_data);
    end
  endtask

  task automatic test_latency(input int which, input int exp_stall);
    int s_n, r_b; logic d_v, s, v; logic [31:0] d;
    sel = which;
    access(1'b1, 32'h8, 32'hA5A5A5A5, s_n, r_b, d_v, d);
    n_vec++;
    if (s_n !== exp_stall) begin
      n_err++; $display("FAIL lat%0d_store_stall: got %0d expected %0d", which, s_n, exp_stall);
    end
    idle(s, v);
    access(1'b0, 32'h8, 32'h0, s_n, r_b, d_v, d);
    n_vec++;
    if (s_n !== exp_stall) begin
      n_err++; $display("FAIL lat%0d_load_stall: got %0d expected %0d", which, s_n, exp_stall);
    end
    n_vec++;
    if (d_v !== 1'b1 || d !== 32'hA5A5A5A5) begin
      n_err++; $display("FAIL lat%0d_load_data: got rdv=%b data=%h expected 1/a5a5a5a5", which, d_v, d);
    end
    idle(s, v);
    n_vec++;
    if (s !== 1'b0 || v !== 1'b0) begin
      n_err++; $display("FAIL lat%0d_after_done: got stall=%b rdv=%b expected 0/0", which, s, v);
    end
    sel = 0;
  endtask

  task automatic test_alias;
    int s_n, r_b; logic d_v, s, v; logic [31:0] d;
    access(1'b1, 32'h0, 32'h11111111, s_n, r_b, d_v, d);
    idle(s, v);
    access(1'b1, 32'h400, 32'h22222222, s_n, r_b, d_v, d);
    idle(s, v);
    access(1'b0, 32'h3, 32'h0, s_n, r_b, d_v, d);
    n_vec++;
    if (d_v !== 1'b1 || d !== 32'h22222222) begin
      n_err++; $display("FAIL alias_load_3: got rdv=%b data=%h expected 1/22222222", d_v, d);
    end
    idle(s, v);
    access(1'b0, 32'h10, 32'h0, s_n, r_b, d_v, d);
    n_vec++;
    if (d !== 32'hDEADBEEF) begin n_err++; $display("FAIL alias_other_word: got %h expected deadbeef", d); end
    idle(s, v);
  endtask

  task automatic test_held_request;
    int s_n, r_b; logic d_v, s, v; logic [31:0] d;
    access(1'b0, 32'h10, 32'h0, s_n, r_b, d_v, d);
    n_vec++;
    if (s_n !== 4 || d_v !== 1'b1) begin
      n_err++; $display("FAIL held_access: got stall=%0d rdv=%b expected 4/1", s_n, d_v);
    end
    idle(s, v);
    n_vec++;
    if (s !== 1'b0 || v !== 1'b0) begin
      n_err++; $display("FAIL held_idle1: got stall=%b rdv=%b expected 0/0", s, v);
    end
    idle(s, v);
    n_vec++;
    if (s !== 1'b0 || v !== 1'b0) begin
      n_err++; $display("FAIL held_idle2: got stall=%b rdv=%b expected 0/0", s, v);
    end
  endtask

  task automatic test_back_to_back;
    int s_n, r_b; logic d_v, s, v; logic [31:0] d;
    access(1'b1, 32'h30, 32'h00000044, s_n, r_b, d_v, d);
    access(1'b0, 32'h30, 32'h0, s_n, r_b, d_v, d);
    n_vec++;
    if (s_n !== 4) begin n_err++; $display("FAIL b2b_load_stall: got %0d expected 4", s_n); end
    n_vec++;
    if (d_v !== 1'b1 || d !== 32'h00000044) begin
      n_err++; $display("FAIL b2b_load_data: got rdv=%b data=%h expected 1/00000044", d_v, d);
    end
    idle(s, v);
  endtask

  task automatic test_reset_mid_store;
    int s_n, r_b; logic d_v, s, v; logic [31:0] d;
    access(1'b1, 32'h20, 32'h5, s_n, r_b, d_v, d);
    idle(s, v);
    access(1'b0, 32'h20, 32'h0, s_n, r_b, d_v, d);
    n_vec++;
    if (d !== 32'h5) begin n_err++; $display("FAIL rms_pre_load: got %h expected 00000005", d); end
    idle(s, v);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    #1;
    n_vec++;
    if (obs_stall !== 1'b1) begin n_err++; $display("FAIL rms_stall_c0: got %b expected 1", obs_stall); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_vec++;
    if (obs_stall !== 1'b0) begin n_err++; $display("FAIL rms_stall_async: got %b expected 0", obs_stall); end
    n_vec++;
    if (obs_rd_data !== 32'h0 || obs_rd_valid !== 1'b0) begin
      n_err++; $display("FAIL rms_rd_reset: got data=%h rdv=%b expected 00000000/0", obs_rd_data, obs_rd_valid);
    end
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_vec++;
    if (obs_stall !== 1'b0) begin n_err++; $display("FAIL rms_release_stall: got %b expected 0", obs_stall); end
    access(1'b0, 32'h20, 32'h0, s_n, r_b, d_v, d);
    n_vec++;
    if (s_n !== 4 || d_v !== 1'b1 || d !== 32'h5) begin
      n_err++; $display("FAIL rms_post_load: got stall=%0d rdv=%b data=%h expected 4/1/00000005", s_n, d_v, d);
    end
    idle(s, v);
  endtask

  task automatic test_req_change;
    int s_n; logic s, v;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_wdata = 32'h0;
    s_n = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!obs_stall) break;
      s_n++;
      @(negedge clk);
      if (i == 0) begin
        req_addr  = 32'h14;
        req_write = 1'b1;
        req_wdata = 32'h0BADBAD0;
      end
      if (i == 1) req_valid = 1'b0;
    end
    n_vec++;
    if (s_n !== 4) begin n_err++; $display("FAIL chg_stall: got %0d expected 4", s_n); end
    n_vec++;
    if (obs_rd_valid !== 1'b1 || obs_rd_data !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL chg_data: got rdv=%b data=%h expected 1/deadbeef", obs_rd_valid, obs_rd_data);
    end
    idle(s, v);
    n_vec++;
    if (s !== 1'b0 || v !== 1'b0) begin
      n_err++; $display("FAIL chg_after: got stall=%b rdv=%b expected 0/0", s, v);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    sel   = 0;
    test_reset;
    test_store_load;
    test_latency(1, 2);
    test_latency(2, 16);
    test_alias;
    test_held_request;
    test_back_to_back;
    test_reset_mid_store;
    test_req_change;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
# mem_responder

Multi-cycle data-memory responder for the MEM stage of the pipelined core. The core's load/store path acts as the initiator. This block is the target end: it accepts one word read or write at a time, holds `stall` high to freeze the pipeline for a fixed access latency, then returns read data or commits write data. It replaces the single-cycle combinational data memory, so the hazard/stall logic can be exercised against realistic memory timing.

## Interface
- `DEPTH`, default 256: memory size in 32-bit words. Must be a power of 2, ≥ 4.
- `LATENCY`, default 3: cycles spent in BUSY per access. Range 1 to 15.
- `clk`  in  1: single clock. All state changes on the rising edge.
- `reset`  in  1: asynchronous, active-low. Low forces all state to reset values immediately.
- `req_valid`  in  1: MEM stage holds a load or store.
- `req_write`  in  1: 1 = store, 0 = load.
- `req_addr`  in  32: byte address. Word index is `req_addr[log2(DEPTH)+1:2]`.
- `req_wdata`  in  32: store data.
- `stall`  out  1: freeze the pipeline (feeds the existing stall muxing).
- `rd_data`  out  32: registered load result.
- `rd_valid`  out  1: one-cycle pulse when `rd_data` holds a new load result.

## Operation
- Internal storage: DEPTH x 32 array. It is not cleared by reset, and its contents are retained across reset.
- FSM states:
  - IDLE: if `req_valid`=1, latch `req_write`, the word index and `req_wdata`. Load counter with LATENCY-1. Go to BUSY.
  - BUSY: if counter≠0, decrement it. If counter=0, perform the access and go to DONE.
    - Store: array[idx] ← wdata.
    - Load: `rd_data` ← array[idx].
  - DONE: always go to IDLE. `req_valid` is ignored in DONE, because the same instruction is still presented while the pipeline advances.
- `stall` is combinational: `stall` = (IDLE ∧ `req_valid`) ∨ BUSY. It is 0 in DONE and 0 while `reset` is low.
- `rd_valid` is registered. It is 1 only in the DONE state that follows a load. It is 0 after a store.
- `rd_data` holds its value until the next load completes. Stores never change it.
- Latched request values are used for the access. Changes on `req_*` during BUSY are ignored, including `req_valid` dropping; the access still completes.
- Address handling:
  - `req_addr[1:0]` is ignored, so misaligned addresses are truncated to the word.
  - Bits above the index are ignored, so addresses wrap modulo DEPTH words.
- Reset mid-operation: return to IDLE immediately. An uncommitted store is discarded. A store commits only at the BUSY→DONE edge.

## Timing
- Request first visible in cycle 0 (IDLE):
  - `stall`=1 in cycles 0 … LATENCY.
  - Cycle LATENCY+1 is DONE: `stall`=0 and, for a load, `rd_valid`=1 with valid `rd_data`.
  - The pipeline advances on the edge ending cycle LATENCY+1.
- Total occupancy is LATENCY+2 cycles per access.
- Back-to-back accesses:
  - The next instruction's request is seen in IDLE at cycle LATENCY+2, giving one non-stalled cycle between accesses.
  - No pipelining and no overlap between accesses.
- Store followed immediately by a load to the same address returns the stored value. The store commits before the load's IDLE cycle.
- Reset values:
  - state IDLE, counter 0.
  - `rd_data` = 0, `rd_valid` = 0, `stall` = 0.
- Reset release:
  - The first rising edge after `reset` goes high is a normal IDLE cycle.
  - `stall` may rise combinationally as soon as `reset` is high and `req_valid`=1.

## Test plan
- Store then load, LATENCY=3:
  - Store 0xDEADBEEF to address 0x10: `stall` high 4 cycles, `rd_valid` stays 0.
  - Load 0x10: `stall` high 4 cycles, then `rd_valid`=1 for one cycle with `rd_data`=0xDEADBEEF.
- Latency sweep, LATENCY=1 and LATENCY=15: load `stall` width is exactly 2 and 16 cycles. DONE has `stall`=0 in both cases.
- Address aliasing, DEPTH=256:
  - Store 0x11111111 to 0x0 and 0x22222222 to 0x400.
  - Load 0x3 returns 0x22222222 (both wrap and misalignment apply).
- Held request in DONE: keep `req_valid`=1 through DONE with the same load. Exactly one access occurs, and `stall` is 0 in DONE and in the following IDLE once `req_valid` drops.
- Reset mid-store:
  - Store 0xCAFEF00D to 0x20, preceded by a load of 0x20 returning 0x5.
  - Pull `reset` low in BUSY with counter=1: `stall` drops asynchronously and `rd_data` = 0.
  - After release, load 0x20 returns 0x5.
- Request change during BUSY: start a load of 0x10, then switch `req_addr` to 0x14 mid-BUSY. `rd_data` returns the 0x10 contents.
